spi_transaction_sequencer: RTL and testbench

Bus-side sequencer that sits directly upstream of the SPI master controller. It accepts one command per transaction (write word plus byte count) over a valid/ready interface and drives the controller's enable, write-data and bytes-valid inputs. It watches the controller's read fill level and captures the read word once the requested byte count has been returned. It then returns that word over a valid/ready response interface.

---
 rtl/spi_pkg.sv | 36 +++
 rtl/spi_seq_sync.sv | 30 +++
 rtl/spi_transaction_sequencer.sv | 169 ++++++++++++++++
 tb/tb_spi_transaction_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transaction sequencer.
package spi_pkg;

  localparam int unsigned SPI_MAX_BYTES        = 4;
  localparam int unsigned SPI_CNT_W            = 3;
  localparam int unsigned SPI_DATA_W           = 32;
  localparam int unsigned SPI_DRAIN_MIN_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [SPI_DATA_W-1:0] wdata;
    logic [SPI_CNT_W-1:0]  nbytes;
  } spi_cmd_t;

  typedef struct packed {
    logic [SPI_DATA_W-1:0] rdata;
    logic                  error;
  } spi_rsp_t;

  // Keeps the low nbytes bytes of a word, zeroes the rest.
  function automatic logic [SPI_DATA_W-1:0] byte_mask(input logic [SPI_CNT_W-1:0] nbytes);
    logic [SPI_DATA_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < SPI_DATA_W / 8; i++) begin
      if (i < 32'(nbytes)) m[8*i +: 8] = 8'hFF;
    end
    return m;
  endfunction

endpackage

// File: rtl/spi_seq_sync.sv
// Two-flop synchroniser for the controller fill level plus a stable-value detector.
module spi_seq_sync
  import spi_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [SPI_CNT_W-1:0] async_cnt,
  output logic [SPI_CNT_W-1:0] sync_cnt,
  output logic                 stable_c
);

  logic [SPI_CNT_W-1:0] meta_q;
  logic [SPI_CNT_W-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta_q   <= '0;
      sync_cnt <= '0;
      prev_q   <= '0;
    end else begin
      meta_q   <= async_cnt;
      sync_cnt <= meta_q;
      prev_q   <= sync_cnt;
    end
  end

  // Nonzero and unchanged over two consecutive cycles.
  assign stable_c = (sync_cnt == prev_q) && (sync_cnt != '0);

endmodule

// File: rtl/spi_transaction_sequencer.sv
// Command/response sequencer in front of the SPI master controller.
// Optional watchdog over RUN+DRAIN is built when SPI_SEQ_TIMEOUT_EN is defined.
module spi_transaction_sequencer
  import spi_pkg::*;
#(
  parameter int unsigned MAX_BYTES        = SPI_MAX_BYTES,
  parameter int unsigned DRAIN_MIN_CYCLES = SPI_DRAIN_MIN_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES   = 4096
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [SPI_DATA_W-1:0] cmd_wdata_i,
  input  logic [SPI_CNT_W-1:0]  cmd_nbytes_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [SPI_DATA_W-1:0] rsp_rdata_o,
  output logic                  rsp_error_o,
  output logic                  busy_o,
  output logic                  spi_enable_o,
  output logic [SPI_DATA_W-1:0] spi_write_data_o,
  output logic [SPI_CNT_W-1:0]  spi_write_bytes_valid_o,
  input  logic [SPI_DATA_W-1:0] spi_read_data_i,
  input  logic [SPI_CNT_W-1:0]  spi_read_bytes_valid_i
);

  localparam int unsigned DRAIN_W = $clog2(DRAIN_MIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MIN_CYCLES - 1);

  // Parameter sanity check.
  if (TIMEOUT_CYCLES == 0) begin : g_tmo_param_check
    $error("TIMEOUT_CYCLES must be nonzero");
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  seq_state_e           state_q, state_d;
  spi_cmd_t             cmd_q, cmd_d;
  spi_rsp_t             rsp_q, rsp_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 enable_d, valid_d, ready_d, busy_d;
  logic                 count_ok;
  logic                 tmo_hit;
  logic [SPI_CNT_W-1:0] sync_cnt;
  logic                 read_stable;

  spi_seq_sync u_sync (
    .clk       (clk_i),
    .rstn      (rstn_i),
    .async_cnt (spi_read_bytes_valid_i),
    .sync_cnt  (sync_cnt),
    .stable_c  (read_stable)
  );

  assign count_ok = (cmd_nbytes_i != '0) && (32'(cmd_nbytes_i) <= MAX_BYTES);

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      rsp_q        <= '0;
      drain_q      <= '0;
      spi_enable_o <= 1'b0;
      rsp_valid_o  <= 1'b0;
      cmd_ready_o  <= 1'b1;
      busy_o       <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      rsp_q        <= rsp_d;
      drain_q      <= drain_d;
      spi_enable_o <= enable_d;
      rsp_valid_o  <= valid_d;
      cmd_ready_o  <= ready_d;
      busy_o       <= busy_d;
`ifdef SPI_SEQ_TIMEOUT_EN
      tmo_q        <= tmo_d;
`endif
    end
  end

  // Next state, payload and output values.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rsp_d   = rsp_q;
    drain_d = drain_q;

`ifdef SPI_SEQ_TIMEOUT_EN
    tmo_d   = tmo_q;
    tmo_hit = 1'b0;
    if (state_q == RUN || state_q == DRAIN) begin
      tmo_hit = (tmo_q == TMO_LAST);
      if (tmo_q != TMO_MAX) tmo_d = tmo_q + TMO_W'(1);
    end
`else
    tmo_hit = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          if (count_ok) begin
            cmd_d   = '{wdata: cmd_wdata_i, nbytes: cmd_nbytes_i};
            rsp_d   = '0;
            state_d = RUN;
`ifdef SPI_SEQ_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end else begin
            rsp_d   = '{rdata: '0, error: 1'b1};
            state_d = RESP;
          end
        end
      end

      RUN: begin
        if (tmo_hit) begin
          rsp_d   = '{rdata: '0, error: 1'b1};
          drain_d = '0;
          state_d = DRAIN;
        end else if (read_stable && sync_cnt == cmd_q.nbytes) begin
          rsp_d   = '{rdata: spi_read_data_i & byte_mask(cmd_q.nbytes), error: 1'b0};
          drain_d = '0;
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        // Bytes the controller finishes after enable falls are ignored here.
        if (drain_q != DRAIN_LAST) drain_d = drain_q + DRAIN_W'(1);
        if (tmo_hit) begin
          rsp_d   = '{rdata: '0, error: 1'b1};
          state_d = RESP;
        end else if (sync_cnt == '0 && drain_q == DRAIN_LAST) begin
          state_d = RESP;
        end
      end

      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    enable_d = (state_d == RUN);
    valid_d  = (state_d == RESP);
    ready_d  = (state_d == IDLE);
    busy_d   = (state_d != IDLE);
  end

  assign rsp_rdata_o             = rsp_q.rdata;
  assign rsp_error_o             = rsp_q.error;
  assign spi_write_data_o        = cmd_q.wdata;
  assign spi_write_bytes_valid_o = cmd_q.nbytes;

endmodule

// File: tb/tb_spi_transaction_sequencer.sv
// Bench for spi_transaction_sequencer: vector table, hand sequences and random transactions
// against a byte-level SPI controller model.
module tb_spi_transaction_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_wdata = '0;
  logic [2:0]  cmd_nbytes = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;
  logic        spi_en;
  logic [31:0] spi_wdata;
  logic [2:0]  spi_bv;
  logic [31:0] spi_rdata = '0;
  logic [2:0]  spi_rbv;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_transaction_sequencer #(.TIMEOUT_CYCLES(64)) dut (
    .clk_i                   (clk),
    .rstn_i                  (rstn),
    .cmd_valid_i             (cmd_valid),
    .cmd_ready_o             (cmd_ready),
    .cmd_wdata_i             (cmd_wdata),
    .cmd_nbytes_i            (cmd_nbytes),
    .rsp_valid_o             (rsp_valid),
    .rsp_ready_i             (rsp_ready),
    .rsp_rdata_o             (rsp_rdata),
    .rsp_error_o             (rsp_error),
    .busy_o                  (busy),
    .spi_enable_o            (spi_en),
    .spi_write_data_o        (spi_wdata),
    .spi_write_bytes_valid_o (spi_bv),
    .spi_read_data_i         (spi_rdata),
    .spi_read_bytes_valid_i  (spi_rbv)
  );

  // Controller model: one byte per byte_cyc negedges while enabled, finishes the
  // byte in flight after enable falls, fill wraps 4->1 and returns to 0 when idle.
  int          txn_id = 0;
  int          byte_cyc = 8;
  logic [31:0] cur_miso = '0;
  bit          m_stuck = 1'b0;
  int          m_last_id = 0;
  int          m_fill = 0;
  int          m_tx = 0;
  int          m_rx = 0;
  int          m_timer = 0;
  int          m_idle = 0;
  int          m_rx_at_fall = -1;
  bit          m_active = 1'b0;
  bit          m_prev_en = 1'b0;
  bit          m_en_seen = 1'b0;
  logic [7:0]  m_mosi [8];

  assign spi_rbv = 3'(m_fill);

  function automatic logic [7:0] miso_byte(input int k);
    logic [31:0] w;
    w = cur_miso;
    if (k < 4) return w[8*k +: 8];
    return 8'h5A;
  endfunction

  always @(negedge clk) begin
    if (txn_id != m_last_id) begin
      m_last_id    = txn_id;
      m_tx         = 0;
      m_rx         = 0;
      m_rx_at_fall = -1;
      m_en_seen    = 1'b0;
    end
    if (spi_en) m_en_seen = 1'b1;
    if (m_prev_en && !spi_en) m_rx_at_fall = m_rx;
    m_prev_en = spi_en;
    if (!m_stuck) begin
      if (m_active) begin
        if (m_timer == 0) begin
          m_fill = (m_fill == 4) ? 1 : m_fill + 1;
          spi_rdata[8*(m_fill-1) +: 8] = miso_byte(m_rx);
          m_rx++;
          m_active = 1'b0;
        end else begin
          m_timer--;
        end
      end
      if (!m_active) begin
        if (spi_en) begin
          int idx;
          idx = int'(spi_bv) - 1 - m_tx;
          if (m_tx < 8) m_mosi[m_tx] = (idx >= 0) ? spi_wdata[8*idx +: 8] : 8'h00;
          m_tx++;
          m_active = 1'b1;
          m_timer  = byte_cyc - 1;
          m_idle   = 0;
        end else if (m_idle < 3) begin
          m_idle++;
        end else begin
          m_fill = 0;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_rdata(input logic [31:0] mi, input logic [2:0] nb);
    logic [31:0] r;
    r = '0;
    if (nb == 3'd0 || nb > 3'd4) return r;
    for (int k = 0; k < int'(nb); k++) r[8*k +: 8] = mi[8*k +: 8];
    return r;
  endfunction

  task automatic start_txn(input string nm, input logic [31:0] wd, input logic [2:0] nb,
                           input logic [31:0] mi, input int bc, output bit ok);
    int n;
    @(negedge clk);
    txn_id++;
    cur_miso = mi;
    byte_cyc = bc;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_wdata  = wd;
    cmd_nbytes = nb;
    n = 0;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = cmd_ready;
    @(negedge clk);
    cmd_valid = 1'b0;
    check({nm, "_accept"}, 32'(ok), 32'd1);
    check({nm, "_busy"}, 32'(busy), 32'd1);
    check({nm, "_ready_low"}, 32'(cmd_ready), 32'd0);
  endtask

  task automatic wait_rsp(input string nm, output bit ok);
    int n;
    n = 0;
    while (!rsp_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok = rsp_valid;
    check({nm, "_rsp_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic do_txn(input string nm, input logic [31:0] wd, input logic [2:0] nb,
                        input logic [31:0] mi, input int bc, input int dly,
                        input logic [31:0] exp_rd, input logic exp_err);
    bit ok;
    start_txn(nm, wd, nb, mi, bc, ok);
    if (!ok) return;
    wait_rsp(nm, ok);
    if (!ok) return;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check({nm, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({nm, "_hold_data"}, rsp_rdata, exp_rd);
      check({nm, "_hold_ready"}, 32'(cmd_ready), 32'd0);
    end
    check({nm, "_rdata"}, rsp_rdata, exp_rd);
    check({nm, "_error"}, 32'(rsp_error), 32'(exp_err));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({nm, "_valid_drop"}, 32'(rsp_valid), 32'd0);
    check({nm, "_ready_back"}, 32'(cmd_ready), 32'd1);
    if (exp_err) begin
      check({nm, "_no_enable"}, 32'(m_en_seen), 32'd0);
    end else begin
      for (int k = 0; k < int'(nb); k++)
        check($sformatf("%s_mosi%0d", nm, k), 32'(m_mosi[k]),
              (wd >> (8 * (int'(nb) - 1 - k))) & 32'hFF);
      check({nm, "_bytes_enabled"}, 32'(m_rx_at_fall), 32'(nb));
    end
  endtask

  typedef struct {
    string       name;
    logic [31:0] wdata;
    logic [2:0]  nbytes;
    logic [31:0] miso;
    int          bcyc;
    int          dly;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    bit ok;
    int n;

    vecs[0] = '{"nom2",  32'h0000A55A, 3'd2, 32'h0077C33C, 8,  1, 32'h0000C33C, 1'b0};
    vecs[1] = '{"full4", 32'hDEADBEEF, 3'd4, 32'h11223344, 9,  0, 32'h11223344, 1'b0};
    vecs[2] = '{"bad0",  32'h12345678, 3'd0, 32'hFFFFFFFF, 8,  2, 32'h00000000, 1'b1};
    vecs[3] = '{"bad5",  32'h87654321, 3'd5, 32'hFFFFFFFF, 8,  0, 32'h00000000, 1'b1};
    vecs[4] = '{"bad7",  32'hA5A5A5A5, 3'd7, 32'hFFFFFFFF, 8,  1, 32'h00000000, 1'b1};
    vecs[5] = '{"one1",  32'hFFFFFF81, 3'd1, 32'hAABBCC5D, 6,  3, 32'h0000005D, 1'b0};
    vecs[6] = '{"three", 32'h00123456, 3'd3, 32'h99887766, 12, 0, 32'h00887766, 1'b0};

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_error", 32'(rsp_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_enable", 32'(spi_en), 32'd0);
    check("rst_wdata", spi_wdata, 32'd0);
    check("rst_bv", 32'(spi_bv), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      do_txn(vecs[i].name, vecs[i].wdata, vecs[i].nbytes, vecs[i].miso, vecs[i].bcyc,
             vecs[i].dly, vecs[i].exp_rdata, vecs[i].exp_err);

    // Backpressure with a second command waiting on the response handshake.
    start_txn("bp", 32'h00001234, 3'd2, 32'h0000ABCD, 7, ok);
    wait_rsp("bp", ok);
    txn_id++;
    cur_miso   = 32'h00000042;
    cmd_valid  = 1'b1;
    cmd_wdata  = 32'h00000099;
    cmd_nbytes = 3'd1;
    repeat (50) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", rsp_rdata, 32'h0000ABCD);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_valid_drop", 32'(rsp_valid), 32'd0);
    check("bp_ready_back", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp_next_busy", 32'(busy), 32'd1);
    check("bp_next_ready", 32'(cmd_ready), 32'd0);
    wait_rsp("bp2", ok);
    check("bp2_rdata", rsp_rdata, 32'h00000042);
    check("bp2_error", 32'(rsp_error), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset pulse while the second byte is on the wire.
    start_txn("rst", 32'hCAFEF00D, 3'd4, 32'h01020304, 10, ok);
    n = 0;
    while (m_rx < 1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_byte2", 32'(m_rx >= 1), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check("rst_mid_enable", 32'(spi_en), 32'd0);
    check("rst_mid_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_ready", 32'(cmd_ready), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_rdata", rsp_rdata, 32'd0);
    repeat (40) @(negedge clk);
    do_txn("post_rst", 32'h000000A7, 3'd1, 32'hFFFFFF3E, 8, 2, 32'h0000003E, 1'b0);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] wd, mi;
      logic [2:0]  nb;
      wd = $urandom;
      mi = $urandom;
      nb = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
      do_txn($sformatf("rnd%0d", i), wd, nb, mi, int'($urandom_range(6, 12)),
             int'($urandom_range(0, 4)), model_rdata(mi, nb), (nb == 3'd0 || nb > 3'd4));
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    // Controller never reports any bytes.
    m_stuck = 1'b1;
    start_txn("tmo", 32'h0000BEEF, 3'd2, 32'h00001111, 8, ok);
    n = 0;
    while (!rsp_valid && n < 64 + 16 + 4) begin
      @(negedge clk);
      n++;
    end
    check("tmo_in_time", 32'(rsp_valid), 32'd1);
    check("tmo_error", 32'(rsp_error), 32'd1);
    check("tmo_rdata", rsp_rdata, 32'd0);
    check("tmo_enable", 32'(spi_en), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    m_stuck = 1'b0;
    check("tmo_ready_back", 32'(cmd_ready), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
